// File: rtl/ascon_pack.sv
// Shared ASCON types and constants: 320-bit state, inverse S-box table and
// the FSM state type of the iterative inverse substitution layer.
// Purely declarative; no latency or flow control of its own.
package ascon_pack;

    // x0 is word 0 and the most significant word of the state.
    typedef logic [63:0] type_state [5];

    localparam logic [4:0] INV_SBOX [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_RUN,
        PS_DONE
    } inv_ps_state_t;

    // Column value is {x0[j],x1[j],x2[j],x3[j],x4[j]} with x0 as MSB.
    function automatic logic [4:0] inv_sbox_col(input logic [4:0] col);
        return INV_SBOX[col];
    endfunction

endpackage

// File: rtl/inv_sbox_col.sv
// Inverse ASCON S-box on one 5-bit bit-column.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
// Ports: col = column {x0..x4}, sub = substituted column.
module inv_sbox_col (
    input  logic [4:0] col,
    output logic [4:0] sub
);

    assign sub = ascon_pack::inv_sbox_col(col);

endmodule

// File: rtl/inv_ps_iter.sv
// Iterative inverse ASCON substitution layer, COLS_PER_CYCLE columns per clock.
// Latency: start sampled at edge 0, done_o pulses after edge 64/COLS_PER_CYCLE.
// Backpressure: start_i ignored while busy; result held until next accepted start.
// Ports: clock_i, reset_i (async, active high), start_i, state_i -> state_o,
//        busy_o (processing), done_o (one-cycle pulse, state_o valid).
module inv_ps_iter
    import ascon_pack::*;
#(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam int N  = 64 / COLS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Divisors of 64 are exactly the powers of two up to 64.
    if (COLS_PER_CYCLE < 1 || COLS_PER_CYCLE > 64 || (64 % COLS_PER_CYCLE) != 0) begin : g_bad_cols
        $error("inv_ps_iter: COLS_PER_CYCLE must be a power of two in 1..64");
    end

    inv_ps_state_t fsm_q;
    type_state     st_q;
    type_state     st_nxt;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    // First column handled this cycle; never exceeds 64 - COLS_PER_CYCLE.
    logic [6:0] base;
    assign base = 7'(cnt_q) * 7'(COLS_PER_CYCLE);

    logic [5:0] col_idx [COLS_PER_CYCLE];
    logic [4:0] col_in  [COLS_PER_CYCLE];
    logic [4:0] col_sub [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        assign col_idx[i] = 6'(base + 7'(i));
        assign col_in[i]  = {st_q[0][col_idx[i]], st_q[1][col_idx[i]], st_q[2][col_idx[i]],
                             st_q[3][col_idx[i]], st_q[4][col_idx[i]]};
        inv_sbox_col u_sbox (
            .col (col_in[i]),
            .sub (col_sub[i])
        );
    end

    // Write the substituted columns back in place; other columns pass through.
    always_comb begin
        st_nxt = st_q;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            for (int w = 0; w < 5; w++) begin
                st_nxt[w][col_idx[i]] = col_sub[i][4-w];
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q  <= PS_IDLE;
            st_q   <= '{default: '0};
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (fsm_q)
                PS_IDLE, PS_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        st_q   <= state_i;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        fsm_q  <= PS_RUN;
                    end else begin
                        busy_q <= 1'b0;
                        fsm_q  <= PS_IDLE;
                    end
                end
                PS_RUN: begin
                    st_q <= st_nxt;
                    if (cnt_q == CW'(N - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fsm_q  <= PS_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    fsm_q  <= PS_IDLE;
                end
            endcase
        end
    end

    assign state_o = st_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_inv_ps_iter.sv
// Scoreboard bench for inv_ps_iter: driver pushes model results, monitor pops on done_o.
// Latency of the default instance is 64/C+1 cycles from the start negedge.
// Extra instances with C=1 and C=64 check latency extremes.
module tb_inv_ps_iter;
    import ascon_pack::*;

    localparam int C = 8;
    localparam int N = 64 / C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic      start;
    type_state st_in, st_out;
    logic      busy, done;

    logic      start1, start64;
    type_state b_in, out1, out64;
    logic      busy1, done1, busy64, done64;

    inv_ps_iter #(.COLS_PER_CYCLE(C)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .state_i(st_in),
        .state_o(st_out), .busy_o(busy), .done_o(done));
    inv_ps_iter #(.COLS_PER_CYCLE(1)) u1 (
        .clock_i(clk), .reset_i(rst), .start_i(start1), .state_i(b_in),
        .state_o(out1), .busy_o(busy1), .done_o(done1));
    inv_ps_iter #(.COLS_PER_CYCLE(64)) u64 (
        .clock_i(clk), .reset_i(rst), .start_i(start64), .state_i(b_in),
        .state_o(out64), .busy_o(busy64), .done_o(done64));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference tables: ASCON forward S-box and its inverse.
    logic [4:0] fwd_tbl [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    logic [4:0] inv_tbl [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};

    typedef struct {
        logic [319:0] orig;
        logic [319:0] exp;
        int           due;
    } op_t;
    op_t q[$];

    int errs = 0;
    int checks = 0;
    int busy_cnt = 0;
    int last_due = 0;
    bit stop = 1'b0;

    function automatic type_state to_st(input logic [319:0] v);
        type_state s;
        for (int w = 0; w < 5; w++) s[w] = v[319-64*w -: 64];
        return s;
    endfunction

    function automatic logic [319:0] to_vec(input type_state s);
        return {s[0], s[1], s[2], s[3], s[4]};
    endfunction

    // Whole-state substitution, every column through the chosen table.
    function automatic logic [319:0] sub_layer(input logic [319:0] v, input bit fwd);
        logic [319:0] r;
        logic [4:0]   col, o;
        r = v;
        for (int j = 0; j < 64; j++) begin
            col = {v[256+j], v[192+j], v[128+j], v[64+j], v[j]};
            o   = fwd ? fwd_tbl[col] : inv_tbl[col];
            {r[256+j], r[192+j], r[128+j], r[64+j], r[j]} = o;
        end
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; start is held for 'hold' edges, state_i scrambled after the first.
    task automatic issue(input logic [319:0] v, input int hold);
        op_t e;
        start    = 1'b1;
        st_in    = to_st(v);
        e.orig   = v;
        e.exp    = sub_layer(v, 1'b0);
        e.due    = cyc + 1 + N;
        last_due = e.due;
        q.push_back(e);
        repeat (hold) begin
            @(negedge clk);
            st_in = to_st(rand320());
        end
        start = 1'b0;
    endtask

    task automatic run_other(input bit wide, input logic [319:0] v);
        int t;
        @(negedge clk);
        b_in = to_st(v);
        if (wide) start64 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start64 = 1'b0;
        t = 1;
        while (!(wide ? done64 : done1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk_int(wide ? "latency_c64" : "latency_c1", t, wide ? 2 : 65);
        chk(wide ? "result_c64" : "result_c1", to_vec(wide ? out64 : out1), sub_layer(v, 1'b0));
        chk(wide ? "roundtrip_c64" : "roundtrip_c1", sub_layer(to_vec(wide ? out64 : out1), 1'b1), v);
    endtask

    logic [319:0] rt_vec;
    logic [319:0] ones;

    initial begin
        type_state s;
        logic [4:0] val;
        rt_vec  = 320'h00001000808c00016cb10ad9ca912f80691aed630e8190ef0c4c36a20853217c46487b3e06d9d7a8;
        ones    = '1;
        start   = 1'b0;
        start1  = 1'b0;
        start64 = 1'b0;
        st_in   = to_st('0);
        b_in    = to_st('0);
        repeat (2) @(negedge clk);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk("reset_state", to_vec(st_out), '0);
        rst = 1'b0;

        fork
            begin : monitor
                op_t e;
                forever begin
                    @(negedge clk);
                    if (stop) break;
                    if (busy) busy_cnt++;
                    if (done) begin
                        if (q.size() == 0) begin
                            checks++;
                            errs++;
                            $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
                        end else begin
                            e = q.pop_front();
                            chk("result", to_vec(st_out), e.exp);
                            chk("roundtrip_ps", sub_layer(to_vec(st_out), 1'b1), e.orig);
                            chk_int("done_latency", cyc, e.due);
                            chk_int("busy_cycles", busy_cnt, N);
                        end
                        busy_cnt = 0;
                    end
                end
            end
            begin : driver
                @(negedge clk);
                issue('0, 1);
                wait_until(last_due + 1);
                issue(ones, 1);
                wait_until(last_due + 1);
                issue(rt_vec, 1);
                wait_until(last_due + 2);
                // start held through RUN with changing state_i, then reload in DONE.
                issue(rand320(), N + 1);
                wait_until(last_due);
                issue(rand320(), 1);
                wait_until(last_due);
                issue(rand320(), 1);
                for (int v = 0; v < 32; v++) begin
                    wait_until(last_due + int'($urandom_range(0, 2)));
                    s = to_st('0);
                    val = 5'(v);
                    for (int w = 0; w < 5; w++) s[w][0] = val[4-w];
                    issue(to_vec(s), 1);
                end
                for (int k = 0; k < 20; k++) begin
                    wait_until(last_due + int'($urandom_range(0, 2)));
                    issue(rand320(), 1);
                end
                // Asynchronous reset in the middle of RUN discards the operation.
                wait_until(last_due + 1);
                issue(rand320(), 1);
                repeat (3) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                chk_int("midrun_reset_busy", int'(busy), 0);
                chk_int("midrun_reset_done", int'(done), 0);
                chk("midrun_reset_state", to_vec(st_out), '0);
                rst = 1'b0;
                void'(q.pop_back());
                busy_cnt = 0;
                @(negedge clk);
                issue(rand320(), 1);
                wait_until(last_due + 2);
                while (q.size() > 0) begin
                    op_t e;
                    e = q.pop_front();
                    checks++;
                    errs++;
                    $display("FAIL missing_done: got no done want done at cycle %0d", e.due);
                end
                run_other(1'b0, rt_vec);
                run_other(1'b1, rt_vec);
                run_other(1'b1, rand320());
                stop = 1'b1;
                @(negedge clk);
            end
        join

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
